// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate-delay sequencer: FSM state encoding
// and the Gray-ordered {a,b} stimulus sweep.
package gate_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   // Sweep order 00, 10, 11, 01 packed LSB-first: entry k lives at bits [2k+1:2k].
   localparam logic [7:0] GRAY_SEQ = {2'b01, 2'b11, 2'b10, 2'b00};

   function automatic logic [1:0] gray_pat(input logic [1:0] idx);
      return GRAY_SEQ[{idx, 1'b0} +: 2];
   endfunction

   function automatic logic [3:0] tt_nibble(input logic [15:0] tt, input logic [1:0] pat);
      return tt[{pat, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/gate_seq_timer.sv
// Per-pattern hold counter: loadable down-counter that stops at one and
// flags its last count.
module gate_seq_timer
   import gate_seq_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         dec_i,
   input  logic [W-1:0] load_val_i,
   output logic         last_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= {W{1'b0}};
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (dec_i && (count_q > W'(1))) begin
         count_q <= count_q - W'(1);
      end else begin
         count_q <= count_q;
      end
   end

   assign last_o = (count_q == W'(1));

endmodule

// File: rtl/gate_delay_sequencer.sv
// Drives a two-input gate block through repeated Gray sweeps, samples its
// outputs after a programmable settle time and counts mismatches.
module gate_delay_sequencer
   import gate_seq_pkg::*;
#(
   parameter int SETTLE_W = 8,
   parameter int LOOPS_W  = 4,
   parameter int ERR_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [SETTLE_W-1:0] settle,
   input  logic [LOOPS_W-1:0]  loops,
   input  logic [15:0]         exp_tt,
   input  logic [3:0]          dut_out,
   output logic                a,
   output logic                b,
   output logic                busy,
   output logic                done,
   output logic                smp_valid,
   output logic [1:0]          smp_pat,
   output logic [3:0]          smp_data,
   output logic [ERR_W-1:0]    err_cnt
);

   state_e              state_q;
   logic                a_q;
   logic                b_q;
   logic                busy_q;
   logic                done_q;
   logic                smp_valid_q;
   logic [1:0]          smp_pat_q;
   logic [3:0]          smp_data_q;
   logic [ERR_W-1:0]    err_cnt_q;
   logic [SETTLE_W-1:0] settle_q;
   logic [LOOPS_W-1:0]  loops_q;
   logic [1:0]          idx_q;

   logic [SETTLE_W-1:0] settle_eff_s;
   logic [LOOPS_W-1:0]  loops_eff_s;
   logic [1:0]          cur_pat_s;
   logic                mismatch_s;
   logic                run_end_s;
   logic [1:0]          idx_d;
   logic [1:0]          pat_d;
   logic [ERR_W-1:0]    err_cnt_d;

   logic                tmr_load_s;
   logic                tmr_dec_s;
   logic [SETTLE_W-1:0] tmr_val_s;
   logic                tmr_last_s;

   always_comb begin
      settle_eff_s = (settle == {SETTLE_W{1'b0}}) ? SETTLE_W'(1) : settle;
      loops_eff_s  = (loops == {LOOPS_W{1'b0}}) ? LOOPS_W'(1) : loops;
      cur_pat_s    = {a_q, b_q};
      mismatch_s   = (dut_out != tt_nibble(exp_tt, cur_pat_s));
      run_end_s    = (idx_q == 2'd3) && (loops_q == LOOPS_W'(1));
      idx_d        = idx_q + 2'd1;
      pat_d        = gray_pat(idx_d);
      // Saturating increment: the counter parks at all-ones.
      if (mismatch_s && (err_cnt_q != {ERR_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   always_comb begin
      tmr_load_s = 1'b0;
      tmr_dec_s  = 1'b0;
      tmr_val_s  = settle_q;
      case (state_q)
         ST_IDLE: begin
            tmr_load_s = start;
            tmr_val_s  = settle_eff_s;
         end
         ST_SETTLE: begin
            if (abort) begin
               tmr_load_s = 1'b0;
            end else if (tmr_last_s) begin
               tmr_load_s = !run_end_s;
            end else begin
               tmr_dec_s = 1'b1;
            end
         end
         default: begin
            tmr_load_s = 1'b0;
         end
      endcase
   end

   gate_seq_timer #(
      .W (SETTLE_W)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load_s),
      .dec_i      (tmr_dec_s),
      .load_val_i (tmr_val_s),
      .last_o     (tmr_last_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         smp_valid_q <= 1'b0;
         smp_pat_q   <= 2'b00;
         smp_data_q  <= 4'h0;
         err_cnt_q   <= {ERR_W{1'b0}};
         settle_q    <= {SETTLE_W{1'b0}};
         loops_q     <= {LOOPS_W{1'b0}};
         idx_q       <= 2'd0;
      end else begin
         done_q      <= 1'b0;
         smp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  settle_q  <= settle_eff_s;
                  loops_q   <= loops_eff_s;
                  idx_q     <= 2'd0;
                  {a_q, b_q} <= gray_pat(2'd0);
                  err_cnt_q <= {ERR_W{1'b0}};
                  busy_q    <= 1'b1;
                  state_q   <= ST_SETTLE;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            ST_SETTLE: begin
               // Abort wins over a sample falling on the same edge.
               if (abort) begin
                  {a_q, b_q} <= 2'b00;
                  done_q     <= 1'b1;
                  state_q    <= ST_DONE;
               end else if (tmr_last_s) begin
                  smp_valid_q <= 1'b1;
                  smp_pat_q   <= cur_pat_s;
                  smp_data_q  <= dut_out;
                  err_cnt_q   <= err_cnt_d;
                  if (run_end_s) begin
                     {a_q, b_q} <= 2'b00;
                     done_q     <= 1'b1;
                     state_q    <= ST_DONE;
                  end else begin
                     {a_q, b_q} <= pat_d;
                     idx_q      <= idx_d;
                     if (idx_q == 2'd3) begin
                        loops_q <= loops_q - LOOPS_W'(1);
                     end else begin
                        loops_q <= loops_q;
                     end
                  end
               end else begin
                  state_q <= ST_SETTLE;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               {a_q, b_q} <= 2'b00;
               busy_q     <= 1'b0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   assign a         = a_q;
   assign b         = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign smp_valid = smp_valid_q;
   assign smp_pat   = smp_pat_q;
   assign smp_data  = smp_data_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: doc/gate_delay_sequencer.md
GATE_DELAY_SEQUENCER -- requirements
Module: gate_delay_sequencer

Interface
REQ-001 Parameter SETTLE_W, default 8, width of the settle-time count.
REQ-002 Parameter LOOPS_W, default 4, width of the sweep-repeat count.
REQ-003 Parameter ERR_W, default 8, width of the mismatch counter.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  begin a run; sampled only in IDLE.
REQ-007 abort  in  1  terminate a run in progress.
REQ-008 settle  in  SETTLE_W  cycles each input pattern is held before sampling; 0 treated as 1.
REQ-009 loops  in  LOOPS_W  number of full 4-pattern sweeps; 0 treated as 1.
REQ-010 exp_tt  in  16  expected gate-block outputs; exp_tt[4p+3:4p] is the expectation for pattern p={a,b}.
REQ-011 dut_out  in  4  gate-block outputs {c,d,e,f}.
REQ-012 a, b  out  1 each  drive to the gate-delay block inputs.
REQ-013 busy  out  1  high while state is not IDLE.
REQ-014 done  out  1  one-cycle pulse at the end of a run, completed or aborted.
REQ-015 smp_valid  out  1  one-cycle pulse; smp_pat and smp_data are valid.
REQ-016 smp_pat  out  2  pattern {a,b} that was sampled.
REQ-017 smp_data  out  4  captured dut_out.
REQ-018 err_cnt  out  ERR_W  number of samples where smp_data != expectation; saturates.

Function
REQ-019 States SHALL be IDLE, SETTLE, DONE; all outputs SHALL be registered.
REQ-020 The pattern order SHALL be the Gray sweep {a,b} = 00, 10, 11, 01, so that one input toggles per step.
REQ-021 In IDLE, start=1 SHALL, on that edge, latch settle and loops (after zero-to-one substitution), drive {a,b}=00, clear err_cnt, load the hold counter with the settle value, and enter SETTLE.
REQ-022 In SETTLE, each edge with counter>1 SHALL decrement the counter, so each pattern is held exactly settle cycles.
REQ-023 On the edge where counter==1, the block SHALL register smp_data<=dut_out and smp_pat<={a,b}, pulse smp_valid, and increment err_cnt on mismatch; on that same edge it SHALL apply the next pattern and reload the counter.
REQ-024 After the sample of pattern 01 in the last sweep, the block SHALL drive {a,b}=00 and enter DONE instead of applying a new pattern.
REQ-025 DONE SHALL last exactly one cycle with done=1 and busy=1, then return to IDLE.
REQ-026 Sweep wrap: after pattern 01, when the loop count is not exhausted, the next pattern SHALL be 00 and the loop counter SHALL be decremented.
REQ-027 start while busy SHALL be ignored; latched settle and loops SHALL NOT change mid-run.
REQ-028 abort in SETTLE SHALL take precedence over sampling on the same edge: no smp_valid, {a,b}<=00, enter DONE; err_cnt is retained.
REQ-029 err_cnt SHALL hold at all-ones, with no wrap.
REQ-030 err_cnt and the last smp_pat/smp_data SHALL hold in IDLE until the next start.

Reset
REQ-031 rst SHALL force IDLE, a=b=0, busy=0, done=0, smp_valid=0, smp_pat=0, smp_data=0, err_cnt=0, and clear the internal counters.
REQ-032 rst SHALL override start and abort in the same cycle.
REQ-033 rst mid-run SHALL end the run without a done pulse.

Structure
REQ-034 A shared package gate_seq_pkg SHALL hold the state enum and the 4-entry Gray pattern constant.
REQ-035 The hold counter SHALL be a sub-module gate_seq_timer with load, decrement and last-count flag.

Verification
REQ-036 Case 1: settle=3, loops=1, start at edge t0, with a model gate block and matching exp_tt -> smp_valid at t0+3, t0+6, t0+9, t0+12; smp_pat=0,2,3,1; err_cnt=0; done for the one cycle after t0+12; busy low from t0+13.
REQ-037 Case 2: settle=0, loops=0 -> behaves as settle=1, loops=1: four samples on consecutive edges, then done.
REQ-038 Case 3: loops=2, exp_tt with pattern 11 wrong -> 8 samples and err_cnt=2.
REQ-039 Case 4: abort on the edge of the second sample -> exactly 1 smp_valid, a=b=0, one done pulse, then IDLE.
REQ-040 Case 5: rst during SETTLE -> all outputs at reset values the next cycle, no done pulse.
REQ-041 Case 6: ERR_W=2, all expectations wrong, loops=2 -> err_cnt saturates at 3.
